// File: rtl/alu_sequencer_if.sv
// Command and response channels between a stimulus source and alu_sequencer.
// The source side uses modport master; the sequencer uses modport slave.
interface alu_sequencer_if #(
   parameter int SIZE  = 8,
   parameter int REP_W = 3
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [5:0]       cmd_sel;
   logic [SIZE-1:0]  cmd_data;
   logic             cmd_cin;
   logic [REP_W-1:0] cmd_rep;
   logic             res_valid;
   logic             res_ready;
   logic [SIZE-1:0]  res_data;
   logic             res_err;

   modport master (
      output cmd_valid, cmd_sel, cmd_data, cmd_cin, cmd_rep, res_ready,
      input  cmd_ready, res_valid, res_data, res_err
   );

   modport slave (
      input  cmd_valid, cmd_sel, cmd_data, cmd_cin, cmd_rep, res_ready,
      output cmd_ready, res_valid, res_data, res_err
   );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one ALU pass per command, plus optional shift-only repeat passes,
// and owns the accumulator that feeds ALU operand a.
module alu_sequencer #(
   parameter int SIZE  = 8,
   parameter int REP_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   alu_sequencer_if.slave     bus,
   output logic [SIZE-1:0]    alu_a,
   output logic [SIZE-1:0]    alu_b,
   output logic               alu_cin,
   output logic [5:0]         alu_sel,
   input  logic [SIZE-1:0]    alu_y,
   output logic [SIZE-1:0]    acc
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] EXEC   = 2'd1;
   localparam logic [1:0] REPEAT = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   localparam logic [REP_W-1:0] REP_ZERO = {REP_W{1'b0}};
   localparam logic [REP_W-1:0] REP_ONE  = {{(REP_W-1){1'b0}}, 1'b1};
   // Idle opcode: no shift, arithmetic a+cin, so alu_y simply mirrors acc.
   localparam logic [5:0]       SEL_IDLE = 6'b100000;

   logic [1:0]       state_r;
   logic [SIZE-1:0]  acc_r;
   logic [SIZE-1:0]  data_r;
   logic [5:0]       sel_r;
   logic             cin_r;
   logic             err_r;
   logic [REP_W-1:0] cnt_r;

   // Control state, latched command fields and accumulator write-back.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         acc_r   <= {SIZE{1'b0}};
         data_r  <= {SIZE{1'b0}};
         sel_r   <= 6'b000000;
         cin_r   <= 1'b0;
         err_r   <= 1'b0;
         cnt_r   <= REP_ZERO;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.cmd_valid) begin
                  sel_r  <= bus.cmd_sel;
                  data_r <= bus.cmd_data;
                  cin_r  <= bus.cmd_cin;
                  cnt_r  <= bus.cmd_rep;
                  // Shift code 01 makes the ALU output undefined: reject it.
                  if (bus.cmd_sel[5:4] == 2'b01) begin
                     err_r   <= 1'b1;
                     state_r <= RESP;
                  end else begin
                     err_r   <= 1'b0;
                     state_r <= EXEC;
                  end
               end
            end
            EXEC: begin
               acc_r <= alu_y;
               if (cnt_r != REP_ZERO) begin
                  state_r <= REPEAT;
               end else begin
                  state_r <= RESP;
               end
            end
            REPEAT: begin
               acc_r <= alu_y;
               cnt_r <= cnt_r - REP_ONE;
               if (cnt_r == REP_ONE) begin
                  state_r <= RESP;
               end else begin
                  state_r <= REPEAT;
               end
            end
            RESP: begin
               if (bus.res_ready) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= RESP;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // ALU drive decoded from registered state only.
   always_comb begin
      alu_a   = acc_r;
      alu_b   = {SIZE{1'b0}};
      alu_cin = 1'b0;
      alu_sel = SEL_IDLE;
      case (state_r)
         EXEC: begin
            alu_b   = data_r;
            alu_cin = cin_r;
            alu_sel = sel_r;
         end
         REPEAT: begin
            alu_sel = {sel_r[5:4], 4'b0000};
         end
         default: begin
            alu_sel = SEL_IDLE;
         end
      endcase
   end

   assign bus.cmd_ready = (state_r == IDLE);
   assign bus.res_valid = (state_r == RESP);
   assign bus.res_data  = acc_r;
   assign bus.res_err   = (state_r == RESP) & err_r;
   assign acc           = acc_r;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command-side controller that drives the 8-bit combinational ALU (opcode bus `sel[5:0]`, operands `a`/`b`, carry `cin`, result `y`) and owns its accumulator.
- Accepts commands over a valid/ready handshake and sequences one ALU pass, plus optional repeated shift-only passes.
- Writes each pass result back into the accumulator and returns the final result over a valid/ready response channel.
- Sits between the instruction/test-stimulus source and the ALU instance.

Parameters:
- SIZE, 8, datapath width; must match the ALU `size`.
- REP_W, 3, width of the repeat-count field.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_sel  input  6  ALU opcode: [5:4] shift, [3] logic/arith, [2:0] function.
- cmd_data  input  SIZE  operand B.
- cmd_cin  input  1  carry-in for the first pass.
- cmd_rep  input  REP_W  number of extra shift-only passes.
- alu_a  output  SIZE  to ALU a (always the accumulator).
- alu_b  output  SIZE  to ALU b.
- alu_cin  output  1  to ALU cin.
- alu_sel  output  6  to ALU sel.
- alu_y  input  SIZE  from ALU y.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_data  output  SIZE  result (the accumulator value).
- res_err  output  1  command was rejected as illegal.
- acc  output  SIZE  accumulator, visible at all times.

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - state=IDLE, acc=0, operand/opcode/cin/count registers=0.
  - res_valid=0, res_err=0, cmd_ready=1 from the first cycle after reset.
  - Reset mid-EXEC, REPEAT or RESP aborts the operation; acc=0, no response is issued.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch sel/data/cin/rep.
    - If cmd_sel[5:4]==2'b01 (the ALU shifter outputs x): go to RESP with res_err=1; acc unchanged.
    - Otherwise go to EXEC with res_err=0.
  - EXEC (1 cycle): alu_a=acc, alu_b=latched data, alu_cin=latched cin, alu_sel=latched sel. At the clock edge acc<=alu_y. Go to REPEAT if count≠0, else RESP.
  - REPEAT (1 cycle per pass): alu_sel={latched sel[5:4],4'b0000} (arith a+cin = pass-through, then shift), alu_cin=0, alu_b=0, alu_a=acc. At the clock edge acc<=alu_y and count-=1. Go to RESP when count reaches 0; otherwise stay.
  - RESP: res_valid=1, res_data=acc, res_err as latched. cmd_ready=0. Hold all outputs stable until res_ready; on res_valid&res_ready go to IDLE next cycle.
- ALU outputs outside EXEC/REPEAT: alu_a=acc, alu_b=0, alu_cin=0, alu_sel=6'b100000 (no shift, arith a+0 = acc).
  - This keeps alu_y=acc, so there are no x values on the ALU while idle.
- alu_* outputs are combinational decode of registered state only. There is no combinational path from cmd_* or res_ready to any output.
- Latency: accept edge at cycle T → res_valid high from T+2+rep, i.e. 2 cycles for rep=0 plus 1 per repeat.
- Throughput: no overlap. cmd_ready=0 from the accept edge until the response handshake completes. cmd_valid outside IDLE is ignored and not queued.
- Arithmetic: all results are modulo 2^SIZE; carry/borrow out is discarded. acc is updated only from alu_y in EXEC/REPEAT, and by reset.
- Repeat count at its maximum value (2^REP_W−1) is legal and gives 2^REP_W−1 extra passes. There is no wrap.
- Illegal opcode takes a single cycle to RESP: res_valid at T+1, res_data=acc unchanged.

Test Plan:
1. Reset → acc=0x00, res_valid=0, res_err=0, cmd_ready=1. While idle, alu_sel=6'b100000 and alu_a=0x00.
2. acc=0x00; cmd_sel=6'b100010 (a+b+cin, no shift), cmd_data=0x05, cmd_cin=1, rep=0 → res_valid at T+2, res_data=0x06, acc=0x06, res_err=0.
3. acc=0x06; cmd_sel=6'b111110 (~a, shift left), rep=0 → ~0x06=0xF9, shifted left = 0xF2; res_data=0xF2.
4. acc=0x81; cmd_sel=6'b000000 (a+cin, shift right), cmd_cin=0, rep=2 → passes give 0x40, 0x20, 0x10. res_valid at T+4, res_data=0x10.
5. cmd_sel=6'b010010 (illegal shift code) with acc=0x10 → res_valid at T+1, res_err=1, res_data=0x10, acc=0x10.
6. Backpressure and reset:
   - Hold res_ready=0 for 3 cycles with cmd_valid=1 throughout → res_valid and res_data held, cmd_ready=0, no second command accepted.
   - Assert rst during REPEAT of a rep=3 command → next cycle acc=0, state IDLE, res_valid never asserted.
